// File: rtl/accum_alu_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, error codes, handshake
// states and the iterative-unit mode select.
package accum_alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'b0000,
        OP_ILLEGAL = 4'b0001,
        OP_ADD     = 4'b0010,
        OP_SUB     = 4'b0011,
        OP_MUL     = 4'b0100,
        OP_DIV     = 4'b0101,
        OP_MOD     = 4'b0110,
        OP_OR      = 4'b0111,
        OP_AND     = 4'b1000,
        OP_XOR     = 4'b1001,
        OP_NAND    = 4'b1010,
        OP_NOR     = 4'b1011,
        OP_XNOR    = 4'b1100,
        OP_NOT     = 4'b1101,
        OP_SET     = 4'b1110,
        OP_CLR     = 4'b1111
    } op_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BORROW  = 2'b01;
    localparam logic [1:0] ERR_DIVZ    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL = 2'b00,
        MD_DIV = 2'b01,
        MD_MOD = 2'b10
    } md_mode_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle over W
// cycles. result is the value produced by the final iteration, valid while done=1.
module iter_muldiv
    import accum_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    input  md_mode_e       mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result
);
    localparam int CW = $clog2(W + 1);

    md_mode_e      mode_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  m_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    opx;
    logic [W:0]    opy;
    logic [W:0]    sum;
    logic [W-1:0]  hi_d;
    logic [W-1:0]  lo_d;

    // {hi,lo} is one shift register: product for mul, remainder:quotient for div/mod.
    always_comb begin
        opx  = '0;
        opy  = '0;
        sum  = '0;
        hi_d = hi_q;
        lo_d = lo_q;
        if (mode_q == MD_MUL) begin
            opx  = {1'b0, hi_q};
            opy  = lo_q[0] ? {1'b0, m_q} : '0;
            sum  = opx + opy;
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
        end else begin
            // Remainder stays below the divisor, so sum[W] is a true borrow flag.
            opx  = {hi_q, lo_q[W-1]};
            opy  = {1'b0, m_q};
            sum  = opx - opy;
            hi_d = sum[W] ? opx[W-1:0] : sum[W-1:0];
            lo_d = {lo_q[W-2:0], ~sum[W]};
        end
    end

    always_comb begin
        result = '0;
        case (mode_q)
            MD_MUL:  result = {hi_d, lo_d};
            MD_DIV:  result = {{W{1'b0}}, lo_d};
            default: result = {{W{1'b0}}, hi_d};
        endcase
    end

    assign done = busy && (cnt_q == CW'(W - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            busy  <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            mode_q <= mode;
            hi_q   <= '0;
            lo_q   <= a;
            m_q    <= b;
        end else if (busy) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/accum_alu.sv
// 2W-bit accumulator ALU: single-cycle add/sub/logic ops, multi-cycle mul/div/mod
// behind a VALID/READY handshake with a one-cycle DONE pulse per completion.
module accum_alu
    import accum_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [W-1:0]   IN,
    input  logic [3:0]     OP,
    input  logic           VALID,
    output logic           READY,
    output logic [2*W-1:0] OUT,
    output logic [1:0]     ERR,
    output logic           DONE
);
    state_e         state_q;
    state_e         state_d;
    logic [2*W-1:0] acc_q;
    logic [1:0]     err_q;
    logic           done_q;
    op_e            op;
    logic [W-1:0]   fbk;
    logic           accept;
    logic           iter_start;
    logic [W:0]     add_sum;
    logic [2*W-1:0] sc_res;
    logic [1:0]     sc_err;
    md_mode_e       md_mode;
    logic           md_busy;
    logic           md_done;
    logic [2*W-1:0] md_res;

    assign op         = op_e'(OP);
    assign fbk        = acc_q[W-1:0];
    assign READY      = (state_q == IDLE);
    assign accept     = VALID && READY;
    assign iter_start = accept && ((op == OP_MUL) ||
                        (((op == OP_DIV) || (op == OP_MOD)) && (IN != '0)));
    assign md_mode    = (op == OP_MUL) ? MD_MUL : (op == OP_DIV) ? MD_DIV : MD_MOD;
    assign add_sum    = {1'b0, fbk} + {1'b0, IN};

    iter_muldiv #(.W(W)) u_muldiv (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (iter_start),
        .mode   (md_mode),
        .a      (fbk),
        .b      (IN),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

    // Mul/div/mod only reach this path with a zero divisor (mul never does).
    always_comb begin
        sc_res = acc_q;
        sc_err = ERR_NONE;
        case (op)
            OP_NOP:     sc_res = acc_q;
            OP_ILLEGAL: sc_err = ERR_ILLEGAL;
            OP_ADD:     sc_res = {{(W-1){1'b0}}, add_sum};
            OP_SUB: begin
                sc_res = {{W{1'b0}}, fbk} - {{W{1'b0}}, IN};
                sc_err = (IN > fbk) ? ERR_BORROW : ERR_NONE;
            end
            OP_MUL, OP_DIV, OP_MOD: begin
                sc_res = '0;
                sc_err = ERR_DIVZ;
            end
            OP_OR:      sc_res = {{W{1'b0}}, fbk | IN};
            OP_AND:     sc_res = {{W{1'b0}}, fbk & IN};
            OP_XOR:     sc_res = {{W{1'b0}}, fbk ^ IN};
            OP_NAND:    sc_res = {{W{1'b0}}, ~(fbk & IN)};
            OP_NOR:     sc_res = {{W{1'b0}}, ~(fbk | IN)};
            OP_XNOR:    sc_res = {{W{1'b0}}, ~(fbk ^ IN)};
            OP_NOT:     sc_res = {{W{1'b0}}, ~fbk};
            OP_SET:     sc_res = '1;
            OP_CLR:     sc_res = '0;
            default:    sc_res = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (iter_start) state_d = BUSY;
            BUSY: if (md_done || !md_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc_q  <= '0;
            err_q  <= ERR_NONE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && !iter_start) begin
                acc_q  <= sc_res;
                err_q  <= sc_err;
                done_q <= 1'b1;
            end else if ((state_q == BUSY) && md_done) begin
                acc_q  <= md_res;
                err_q  <= ERR_NONE;
                done_q <= 1'b1;
            end
        end
    end

    assign OUT  = acc_q;
    assign ERR  = err_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu at W=16 and W=8: expected results are queued
// when a request is driven and matched against each DONE pulse.
module tb_accum_alu;
    import accum_alu_pkg::*;

    localparam int W  = 16;
    localparam int W8 = 8;

    typedef struct packed {
        logic [31:0] out;
        logic [1:0]  err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in16;
    logic [3:0]    op16;
    logic          valid16;
    logic          ready16;
    logic [31:0]   out16;
    logic [1:0]    err16;
    logic          done16;
    logic [W8-1:0] in8;
    logic [3:0]    op8;
    logic          valid8;
    logic          ready8;
    logic [15:0]   out8;
    logic [1:0]    err8;
    logic          done8;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t exp8_q[$];
    res_t obs8_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    always #5 clk = ~clk;

    accum_alu #(.W(W)) dut16 (
        .CLK(clk), .RST_N(rst_n), .IN(in16), .OP(op16), .VALID(valid16),
        .READY(ready16), .OUT(out16), .ERR(err16), .DONE(done16)
    );

    accum_alu #(.W(W8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .IN(in8), .OP(op8), .VALID(valid8),
        .READY(ready8), .OUT(out8), .ERR(err8), .DONE(done8)
    );

    always @(posedge clk) begin
        #1;
        if (done16) obs_q.push_back({out16, err16});
        if (done8)  obs8_q.push_back({16'h0000, out8, err8});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue16(input logic [3:0] op, input logic [W-1:0] val);
        op16 = op; in16 = val; valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [W8-1:0] val);
        op8 = op; in8 = val; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
    endtask

    task automatic wait_done16(input int max_cyc, output int cyc);
        cyc = 0;
        while (done16 !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done8(input int max_cyc, output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid16 = 1'b0; op16 = OP_NOP; in16 = '0;
        valid8  = 1'b0; op8  = OP_NOP; in8  = '0;
        repeat (3) tick();
        chk_cnt++;
        if (out16 !== 32'h0 || err16 !== ERR_NONE || done16 !== 1'b0 || ready16 !== 1'b1)
            $display("FAIL reset16: out=%h err=%b done=%b ready=%b, want 0/00/0/1", out16, err16, done16, ready16);
        else pass_cnt++;
        chk_cnt++;
        if (out8 !== 16'h0 || err8 !== ERR_NONE || done8 !== 1'b0 || ready8 !== 1'b1)
            $display("FAIL reset8: out=%h err=%b done=%b ready=%b, want 0/00/0/1", out8, err8, done8, ready8);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        res_t e, o;
        exp_q.push_back({32'h0, ERR_NONE}); issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'h3, ERR_NONE}); issue16(OP_ADD, 16'h3);
        issue16(OP_MUL, 16'h0005);
        repeat (4) tick();
        rst_n = 1'b0; valid16 = 1'b1; op16 = OP_SET; in16 = 16'h0;
        tick();
        rst_n = 1'b1; valid16 = 1'b0;
        chk_cnt++;
        if (out16 !== 32'h0 || err16 !== ERR_NONE || done16 !== 1'b0 || ready16 !== 1'b1)
            $display("FAIL reset_mid_mul: out=%h err=%b done=%b ready=%b, want 0/00/0/1", out16, err16, done16, ready16);
        else pass_cnt++;
        repeat (W + 4) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL reset_mid_mul result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL reset_mid_mul result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (obs_q.size() != 0 || out16 !== 32'h0)
            $display("FAIL reset_mid_mul aftermath: extra dones=%0d out=%h, want 0/0", obs_q.size(), out16);
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_add_chain();
        res_t e, o;
        exp_q.push_back({32'h0, ERR_NONE});        issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'h00001234, ERR_NONE}); issue16(OP_ADD, 16'h1234);
        tick();
        chk_cnt++;
        if (done16 !== 1'b0) $display("FAIL add_done_width: done=%b one cycle after pulse, want 0", done16);
        else pass_cnt++;
        exp_q.push_back({32'hFFFFFFFF, ERR_NONE}); issue16(OP_SET, 16'h0);
        exp_q.push_back({32'h00010000, ERR_NONE}); issue16(OP_ADD, 16'h0001);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL add_chain result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL add_chain result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mul_latency();
        res_t e, o;
        int   n;
        bit   moved;
        exp_q.push_back({32'h0, ERR_NONE});        issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'h0000FFFF, ERR_NONE}); issue16(OP_ADD, 16'hFFFF);
        exp_q.push_back({32'hFFFE0001, ERR_NONE});
        exp_q.push_back({32'h0000FFFF, ERR_NONE});
        op16 = OP_MUL; in16 = 16'hFFFF; valid16 = 1'b1;
        tick();
        n = 0; moved = 1'b0;
        while (ready16 !== 1'b1 && n < 40) begin
            if (out16 !== 32'h0000FFFF) moved = 1'b1;
            tick();
            n++;
        end
        chk_cnt++;
        if (n != W) $display("FAIL mul_ready_low: READY low for %0d cycles, want %0d", n, W);
        else pass_cnt++;
        chk_cnt++;
        if (moved) $display("FAIL mul_out_stable: OUT changed while busy, want held at 0000ffff");
        else pass_cnt++;
        chk_cnt++;
        if (out16 !== 32'hFFFE0001 || done16 !== 1'b1)
            $display("FAIL mul_at_tW: out=%h done=%b, want fffe0001/1", out16, done16);
        else pass_cnt++;
        tick();
        valid16 = 1'b0;
        chk_cnt++;
        if (ready16 !== 1'b0) $display("FAIL mul_held_accept: ready=%b at t+W+1, want 0", ready16);
        else pass_cnt++;
        wait_done16(40, n);
        chk_cnt++;
        if (n != W) $display("FAIL mul2_latency: done after %0d cycles, want %0d", n, W);
        else pass_cnt++;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL mul result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL mul result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_divmod();
        res_t e, o;
        int   n;
        exp_q.push_back({32'h0, ERR_NONE});  issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'd100, ERR_NONE}); issue16(OP_ADD, 16'd100);
        exp_q.push_back({32'd14, ERR_NONE});  issue16(OP_DIV, 16'd7);
        wait_done16(40, n);
        chk_cnt++;
        if (n != W) $display("FAIL div_latency: done after %0d cycles, want %0d", n, W);
        else pass_cnt++;
        exp_q.push_back({32'h0, ERR_NONE});  issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'd100, ERR_NONE}); issue16(OP_ADD, 16'd100);
        exp_q.push_back({32'd2, ERR_NONE});   issue16(OP_MOD, 16'd7);
        wait_done16(40, n);
        exp_q.push_back({32'h0, ERR_DIVZ});   issue16(OP_DIV, 16'd0);
        chk_cnt++;
        if (done16 !== 1'b1 || ready16 !== 1'b1)
            $display("FAIL div0_single_cycle: done=%b ready=%b after accept, want 1/1", done16, ready16);
        else pass_cnt++;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL divmod result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL divmod result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_borrow();
        res_t e, o;
        exp_q.push_back({32'h0, ERR_NONE});          issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'h5, ERR_NONE});          issue16(OP_ADD, 16'h5);
        exp_q.push_back({32'hFFFFFFFE, ERR_BORROW}); issue16(OP_SUB, 16'h7);
        exp_q.push_back({32'h000000FE, ERR_NONE});   issue16(OP_AND, 16'h00FF);
        exp_q.push_back({32'h000000FE, ERR_ILLEGAL}); issue16(OP_ILLEGAL, 16'h1234);
        tick();
        chk_cnt++;
        if (err16 !== ERR_ILLEGAL) $display("FAIL err_hold: err=%b after idle cycle, want 11", err16);
        else pass_cnt++;
        exp_q.push_back({32'h000000FE, ERR_NONE});   issue16(OP_NOP, 16'hFFFF);
        exp_q.push_back({32'h000000FC, ERR_NONE});   issue16(OP_SUB, 16'h2);
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL borrow result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL borrow result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        exp_q.push_back({32'h0, ERR_NONE});        issue16(OP_CLR, 16'h0);
        exp_q.push_back({32'h1, ERR_NONE});
        exp_q.push_back({32'h3, ERR_NONE});
        exp_q.push_back({32'hF3, ERR_NONE});
        exp_q.push_back({32'h0000FF0C, ERR_NONE});
        valid16 = 1'b1;
        op16 = OP_ADD; in16 = 16'h0001; tick();
        op16 = OP_ADD; in16 = 16'h0002; tick();
        op16 = OP_XOR; in16 = 16'h00F0; tick();
        op16 = OP_NOT; in16 = 16'h0000; tick();
        valid16 = 1'b0;
        tick();
        chk_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: %0d completions, want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); chk_cnt++;
            if (obs_q.size() == 0) $display("FAIL b2b result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_w8();
        res_t e, o;
        int   n;
        exp8_q.push_back({32'h0, ERR_NONE});      issue8(OP_CLR, 8'h00);
        exp8_q.push_back({32'hFF, ERR_NONE});     issue8(OP_ADD, 8'hFF);
        exp8_q.push_back({32'hFE01, ERR_NONE});   issue8(OP_MUL, 8'hFF);
        wait_done8(40, n);
        chk_cnt++;
        if (n != W8) $display("FAIL w8_mul_latency: done after %0d cycles, want %0d", n, W8);
        else pass_cnt++;
        exp8_q.push_back({32'h0, ERR_NONE});      issue8(OP_CLR, 8'h00);
        exp8_q.push_back({32'hFF, ERR_NONE});     issue8(OP_ADD, 8'hFF);
        exp8_q.push_back({32'h000F, ERR_NONE});   issue8(OP_DIV, 8'h10);
        wait_done8(40, n);
        exp8_q.push_back({32'h0, ERR_NONE});      issue8(OP_CLR, 8'h00);
        exp8_q.push_back({32'hFF, ERR_NONE});     issue8(OP_ADD, 8'hFF);
        exp8_q.push_back({32'h000F, ERR_NONE});   issue8(OP_MOD, 8'h10);
        wait_done8(40, n);
        tick();
        while (exp8_q.size() > 0) begin
            e = exp8_q.pop_front(); chk_cnt++;
            if (obs8_q.size() == 0) $display("FAIL w8 result: got none, want %h/%b", e.out, e.err);
            else begin
                o = obs8_q.pop_front();
                if (o !== e) $display("FAIL w8 result: got %h/%b, want %h/%b", o.out, o.err, e.out, e.err);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_add_chain();
        test_mul_latency();
        test_divmod();
        test_borrow();
        test_back_to_back();
        test_w8();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/accum_alu.md
# accum_alu

Parametrised, multi-cycle successor to the 16-bit accumulator ALU. It holds a 2W-bit accumulator and applies one opcode per accepted request, using the accumulator's low W bits as the left operand (FBK) and IN as the right operand. Add, subtract, logic, preset and reset complete in one cycle. Multiply, divide and modulo run iteratively over W cycles behind a VALID/READY handshake with a DONE pulse. It replaces the purely combinational mul/div/mod datapath and adds a real reset.

## Interface
Parameters:
- W, 16: operand width. Accumulator/OUT is 2W bits. Legal range is W ≥ 4.

Ports:
- Clock and reset are decided: one clock, CLK; reset RST_N is synchronous and active-low.
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  synchronous active-low reset
- IN  in  W  right operand
- OP  in  4  opcode, sampled at accept
- VALID  in  1  request present
- READY  out  1  high when IDLE; accept = VALID & READY at a rising edge
- OUT  out  2W  accumulator
- ERR  out  2  error code of the last completed op: 00 none, 01 subtract borrow, 10 divide/mod by zero, 11 illegal opcode
- DONE  out  1  one-cycle pulse per completed op

## Operation
- Opcodes:
  - 0000 nop
  - 0001 illegal
  - 0010 add
  - 0011 sub
  - 0100 mul
  - 0101 div
  - 0110 mod
  - 0111 or
  - 1000 and
  - 1001 xor
  - 1010 nand
  - 1011 nor
  - 1100 xnor
  - 1101 not (~FBK)
  - 1110 preset (all ones)
  - 1111 clear (all zeros)
- Logic results are W bits, zero-extended to 2W.
- add: OUT ← zero-extended FBK + IN, W+1 significant bits; never an error.
- sub: OUT ← (FBK − IN) mod 2^(2W); ERR=01 iff IN > FBK.
- mul: OUT ← FBK × IN, full 2W bits, shift-add, one partial product per cycle.
- div/mod: restoring division, one quotient bit per cycle; OUT ← zero-extended quotient or remainder.
- div/mod with IN = 0: no iteration; OUT ← 0, ERR=10, completes as a single-cycle op.
- nop: OUT unchanged, ERR ← 00.
- illegal (0001): OUT unchanged, ERR ← 11.
- Every completion rewrites ERR; ERR holds until the next completion.
- State machine:
  - IDLE → IDLE on accept of a single-cycle op.
  - IDLE → BUSY on accept of mul or div/mod with a nonzero divisor.
  - BUSY → IDLE after the W-th iteration.
- Operands (FBK, IN) and OP are latched at accept. IN, OP and VALID are ignored while BUSY.
- A requester holding VALID through BUSY is accepted at the first edge where READY=1.

## Timing
- Reset: any edge with RST_N=0, including mid-BUSY, forces:
  - state IDLE
  - OUT=0, ERR=00, DONE=0
  - the in-flight op discarded
  - READY=1 from the following cycle
  - VALID ignored at that edge
- Single-cycle op accepted at edge t: OUT/ERR updated at edge t; DONE=1 for cycle t→t+1; READY stays 1, so back-to-back accepts are legal.
- Iterative op accepted at edge t:
  - READY=0 from t until edge t+W.
  - Iterations run at edges t+1…t+W.
  - OUT/ERR written at edge t+W; DONE=1 for cycle t+W→t+W+1; READY=1 in that same cycle, so a new accept is possible at edge t+W+1.
- OUT is stable while BUSY; intermediate state lives in internal registers only.
- DONE is never high for two consecutive cycles from the same op.

## Structure
- Shared package accum_alu_pkg holds:
  - opcode localparams/enum (OP_NOP…OP_CLR)
  - ERR codes (ERR_NONE, ERR_BORROW, ERR_DIVZ, ERR_ILLEGAL)
  - state enum (IDLE, BUSY)
- Sub-module iter_muldiv #(W):
  - inputs: start, mode (mul/div/mod), a, b
  - outputs: busy, done, result[2W-1:0]
  - shared shift register plus W+1-bit adder/subtractor, iteration counter of $clog2(W+1) bits
- Top level holds the accumulator, single-cycle datapath, handshake FSM, ERR/DONE registers.

## Test plan
- Reset mid-mul: accept mul, pull RST_N low at edge t+5 → OUT=0, ERR=00, DONE never pulses, READY=1 from the next cycle.
- Add chain, W=16: clear, add 0x1234 → OUT=0x00001234, DONE one cycle. Then preset, add 0x0001 → OUT=0x00010000, ERR=00.
- Mul latency, W=16: OUT=0x0000FFFF, mul 0xFFFF with VALID held after accept → OUT=0xFFFE0001 at exactly edge t+16. READY=0 for 16 cycles; the held request is accepted at edge t+17.
- Div/mod, W=16:
  - OUT=100, div 7 → 14, ERR=00.
  - Reload 100, mod 7 → 2.
  - div 0 → OUT=0, ERR=10, DONE one cycle after accept.
- Borrow and clear, W=16: OUT=5, sub 7 → OUT=0xFFFFFFFE, ERR=01. Then and 0x00FF → OUT=0x000000FE, ERR=00. Then op 0001 → OUT unchanged, ERR=11.
- Parameter, W=8: OUT=0xFF, mul 0xFF → OUT=0xFE01 after 8 cycles. div 0x10 from 0xFF → 0x000F.
